// File: rtl/barrier_sched.sv
// Fair two-process scheduler feeding the barrier model's select/pause inputs.
// Define BARRIER_SCHED_FAIR_EN to enable starvation forcing; otherwise wait counters are observation only.
module barrier_sched #(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CW       = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1:0]    req,
  input  logic          choice,
  output logic          select,
  output logic          pause,
  output logic          forced,
  output logic [CW-1:0] wait0,
  output logic [CW-1:0] wait1
);

  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  logic          s;
  logic          pause_n;
  logic          forced_n;
  logic [CW-1:0] wait0_n;
  logic [CW-1:0] wait1_n;

`ifdef BARRIER_SCHED_FAIR_EN
  logic last;
  logic sat0;
  logic sat1;

  assign sat0 = (wait0 >= WMAX);
  assign sat1 = (wait1 >= WMAX);

  // last starts at 1 so process 0 wins the first doubly-saturated tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last <= 1'b1;
    else          last <= s;
  end
`endif

  always_comb begin
    s        = choice;
    forced_n = 1'b0;
    case (req)
      2'b01: s = 1'b0;
      2'b10: s = 1'b1;
`ifdef BARRIER_SCHED_FAIR_EN
      2'b11: begin
        if (sat0 && sat1) begin
          s        = ~last;
          forced_n = 1'b1;
        end else if (sat0) begin
          s        = 1'b0;
          forced_n = 1'b1;
        end else if (sat1) begin
          s        = 1'b1;
          forced_n = 1'b1;
        end
      end
`endif
      default: s = choice;
    endcase

    pause_n = ~req[s];

    // a dropped request clears its counter ahead of any increment
    if (s == 1'b0 || !req[0])  wait0_n = '0;
    else if (wait0 >= WMAX)    wait0_n = WMAX;
    else                       wait0_n = wait0 + CW'(1);

    if (s == 1'b1 || !req[1])  wait1_n = '0;
    else if (wait1 >= WMAX)    wait1_n = WMAX;
    else                       wait1_n = wait1 + CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      select <= 1'b0;
      pause  <= 1'b1;
      forced <= 1'b0;
      wait0  <= '0;
      wait1  <= '0;
    end else begin
      select <= s;
      pause  <= pause_n;
      forced <= forced_n;
      wait0  <= wait0_n;
      wait1  <= wait1_n;
    end
  end

endmodule

// File: tb/tb_barrier_sched.sv
// Scoreboard bench for barrier_sched with MAX_WAIT=3, CW=4; follows BARRIER_SCHED_FAIR_EN like the DUT.
module tb_barrier_sched;

  localparam int unsigned MW = 3;

  typedef struct packed {
    logic       sel;
    logic       pause;
    logic       forced;
    logic [3:0] w0;
    logic [3:0] w1;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b11;
  logic       choice = 1'b1;
  logic       select, pause, forced;
  logic [3:0] wait0, wait1;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  exp_t e;

  // independent reference state
  logic       m_last;
  logic [3:0] m_w0, m_w1;

  barrier_sched #(.MAX_WAIT(MW), .CW(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .choice (choice),
    .select (select),
    .pause  (pause),
    .forced (forced),
    .wait0  (wait0),
    .wait1  (wait1)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] bump(input logic [3:0] w);
    return (w >= 4'(MW)) ? 4'(MW) : w + 4'd1;
  endfunction

  task automatic model_reset();
    m_last = 1'b1;
    m_w0   = '0;
    m_w1   = '0;
    sb.delete();
  endtask

  // drive one cycle of stimulus, push the expected registered result, step past the edge
  task automatic step(input logic [1:0] r, input logic c);
    exp_t x;
    logic s, f;
    req = r;
    choice = c;
    f = 1'b0;
    if (r == 2'b01)      s = 1'b0;
    else if (r == 2'b10) s = 1'b1;
    else                 s = c;
`ifdef BARRIER_SCHED_FAIR_EN
    if (r == 2'b11) begin
      if (m_w0 >= 4'(MW) && m_w1 >= 4'(MW)) begin s = !m_last; f = 1'b1; end
      else if (m_w0 >= 4'(MW))              begin s = 1'b0;    f = 1'b1; end
      else if (m_w1 >= 4'(MW))              begin s = 1'b1;    f = 1'b1; end
    end
`endif
    x.sel    = s;
    x.pause  = (s == 1'b0) ? !r[0] : !r[1];
    x.forced = f;
    x.w0     = (s == 1'b0 || !r[0]) ? 4'd0 : bump(m_w0);
    x.w1     = (s == 1'b1 || !r[1]) ? 4'd0 : bump(m_w1);
    m_last   = s;
    m_w0     = x.w0;
    m_w1     = x.w1;
    sb.push_back(x);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    req = 2'b11;
    choice = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      total++;
      if ({select, pause, forced, wait0, wait1} !== {1'b1 == 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}) begin
        bad++;
        $display("FAIL reset_hold: got %b%b%b %0d %0d expected 010 0 0", select, pause, forced, wait0, wait1);
      end
    end
    reset_n = 1'b1;
    step(2'b11, 1'b1);
    e = sb.pop_front();
    total++;
    if ({select, pause, forced, wait0, wait1} !== e || select !== 1'b1 || pause !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got %b%b%b %0d %0d expected %b%b%b %0d %0d",
               select, pause, forced, wait0, wait1, e.sel, e.pause, e.forced, e.w0, e.w1);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 1'b0);
      e = sb.pop_front();
      total++;
      if ({select, pause, forced, wait0, wait1} !== e || select !== 1'b1 || pause !== 1'b0 ||
          wait0 !== 4'd0 || wait1 !== 4'd0) begin
        bad++;
        $display("FAIL single_req[%0d]: got %b%b%b %0d %0d expected %b%b%b %0d %0d", i,
                 select, pause, forced, wait0, wait1, e.sel, e.pause, e.forced, e.w0, e.w1);
      end
    end
  endtask

  task automatic test_starvation();
    logic [7:0] sel_tab;
    logic [7:0] frc_tab;
    logic [3:0] w1_tab [8];
`ifdef BARRIER_SCHED_FAIR_EN
    sel_tab = 8'b1000_1000;  // bit i is cycle i
    frc_tab = 8'b1000_1000;
    w1_tab  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
`else
    sel_tab = 8'b0000_0000;
    frc_tab = 8'b0000_0000;
    w1_tab  = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
`endif
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 1'b0);
      e = sb.pop_front();
      total++;
      if ({select, pause, forced, wait0, wait1} !== e || select !== sel_tab[i] ||
          forced !== frc_tab[i] || wait1 !== w1_tab[i]) begin
        bad++;
        $display("FAIL starvation[%0d]: got sel=%b frc=%b w1=%0d expected sel=%b frc=%b w1=%0d", i,
                 select, forced, wait1, sel_tab[i], frc_tab[i], w1_tab[i]);
      end
    end
  endtask

  task automatic test_drop_saturated();
    int n = 0;
    while (m_w1 != 4'd3 && n < 8) begin
      step(2'b11, 1'b0);
      e = sb.pop_front();
      n++;
    end
    total++;
    if (wait1 !== 4'd3) begin
      bad++;
      $display("FAIL drop_setup: got wait1=%0d expected 3", wait1);
    end
    step(2'b01, 1'b0);
    e = sb.pop_front();
    total++;
    if ({select, pause, forced, wait0, wait1} !== e || wait1 !== 4'd0 || select !== 1'b0 || forced !== 1'b0) begin
      bad++;
      $display("FAIL drop_saturated: got sel=%b frc=%b w1=%0d expected sel=0 frc=0 w1=0", select, forced, wait1);
    end
  endtask

  task automatic test_mid_reset();
    step(2'b11, 1'b0);
    e = sb.pop_front();
    step(2'b11, 1'b0);
    e = sb.pop_front();
    total++;
    if ({select, pause, forced, wait0, wait1} !== e || wait1 !== 4'd2) begin
      bad++;
      $display("FAIL midreset_setup: got wait1=%0d expected 2", wait1);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({select, pause, forced, wait0, wait1} !== {1'b0, 1'b1, 1'b0, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL midreset_async: got %b%b%b %0d %0d expected 010 0 0", select, pause, forced, wait0, wait1);
    end
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      step(2'($urandom_range(3)), 1'($urandom_range(1)));
      e = sb.pop_front();
      total++;
      if ({select, pause, forced, wait0, wait1} !== e) begin
        bad++;
        $display("FAIL random[%0d]: got %b%b%b %0d %0d expected %b%b%b %0d %0d", i,
                 select, pause, forced, wait0, wait1, e.sel, e.pause, e.forced, e.w0, e.w1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_starvation();
    test_drop_saturated();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
